// File: rtl/commit_sequencer.sv
// In-order retirement control for the reorder buffer: tag allocation, CDB completion, mispredict flush.
// Optional macro COMMIT_PERF_EN adds retiredCount/flushCount performance counters.
module commit_sequencer #(
  parameter int ROB   = 2,
  parameter int WIDTH = 31
) (
  input  logic           clk,
  input  logic           resetN,
  input  logic           allocReq,
  output logic           allocGrant,
  output logic [ROB:0]   allocTag,
  output logic           full,
  input  logic           cdbValid,
  input  logic [ROB:0]   cdbTag,
  input  logic           cdbMispredict,
  input  logic [WIDTH:0] cdbTarget,
  input  logic           commitStall,
  output logic           commitValid,
  output logic [ROB:0]   commitTag,
  output logic           redirect,
  output logic [WIDTH:0] redirectPC,
  output logic           flush,
  output logic [ROB+1:0] count
`ifdef COMMIT_PERF_EN
  ,
  output logic [31:0]    retiredCount,
  output logic [31:0]    flushCount
`endif
);

  localparam int ENTRIES = 1 << (ROB + 1);
  localparam logic [ROB+1:0] FULL_CNT = (ROB + 2)'(ENTRIES);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t               state_q, state_d;
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [ENTRIES-1:0]   done_q, done_d;
  logic [ENTRIES-1:0]   misp_q, misp_d;
  logic [WIDTH:0]       target_q [ENTRIES];
  logic [ROB:0]         head_q, head_d;
  logic [ROB:0]         tail_q, tail_d;
  logic [ROB+1:0]       count_q, count_d;
  logic                 run;
  logic                 cdb_hit;

  assign run         = (state_q == RUN);
  assign full        = (count_q == FULL_CNT);
  assign count       = count_q;
  assign flush       = (state_q == FLUSH);
  assign allocGrant  = run & allocReq & ~full;
  assign allocTag    = tail_q;
  assign commitTag   = head_q;
  assign commitValid = run & valid_q[head_q] & done_q[head_q] & ~commitStall;
  assign redirect    = commitValid & misp_q[head_q];
  assign redirectPC  = redirect ? target_q[head_q] : '0;
  assign cdb_hit     = run & cdbValid & valid_q[cdbTag];

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = done_q;
    misp_d  = misp_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (state_q == FLUSH) begin
      state_d = RUN;
    end else if (redirect) begin
      // Retiring a mispredict discards every younger entry, including any grant made this cycle.
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = FLUSH;
    end else begin
      if (cdb_hit) begin
        done_d[cdbTag] = 1'b1;
        if (cdbMispredict) misp_d[cdbTag] = 1'b1;
      end
      if (commitValid) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (allocGrant) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        misp_d[tail_q]  = 1'b0;
        tail_d          = tail_q + 1'b1;
      end
      case ({allocGrant, commitValid})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= RUN;
      valid_q <= '0;
      done_q  <= '0;
      misp_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      misp_q  <= misp_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Targets are only observable through a valid mispredicted head, so they need no reset.
  always_ff @(posedge clk) begin
    if (cdb_hit && cdbMispredict) target_q[cdbTag] <= cdbTarget;
  end

`ifdef COMMIT_PERF_EN
  logic [31:0] retired_q, flushes_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      retired_q <= '0;
      flushes_q <= '0;
    end else begin
      if (commitValid) retired_q <= retired_q + 32'd1;
      if (redirect)    flushes_q <= flushes_q + 32'd1;
    end
  end

  assign retiredCount = retired_q;
  assign flushCount   = flushes_q;
`endif

endmodule
